ctrl_issue_seq: RTL

CTRL_ISSUE_SEQ -- requirements
Module: ctrl_issue_seq

---
 rtl/ctrl_issue_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_issue_seq.sv
// ctrl_issue_seq -- opcode issue sequencer for an external combinational
// control decoder.
//
// Opcodes are queued in a DEPTH-entry FIFO. A small FSM pops one opcode at a
// time into op_reg and drives it to the decoder on dec_in. It captures the
// returned control word on the DECODE edge and holds it on cw_word/cw_valid
// until the consumer takes it.
//
// Optional build macro: CTRL_ISSUE_SEQ_STATS_EN adds a saturating 16-bit
// issue_cnt output that counts control-word handshakes.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   op_valid  - requester presents op_code
//   op_code   - 7-bit opcode
//   op_ready  - FIFO can accept an opcode (not full)
//   dec_in    - opcode to the external decoder (always op_reg)
//   dec_out   - 26-bit control word from the decoder
//   cw_valid  - cw_word holds an unconsumed control word
//   cw_word   - registered control word
//   cw_ready  - consumer accepts cw_word
//   busy      - FIFO non-empty or FSM not idle
//   issue_cnt - (CTRL_ISSUE_SEQ_STATS_EN only) handshake count, saturating
module ctrl_issue_seq #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [6:0]  op_code,
   output logic        op_ready,
   output logic [6:0]  dec_in,
   input  logic [25:0] dec_out,
   output logic        cw_valid,
   output logic [25:0] cw_word,
   input  logic        cw_ready,
   output logic        busy
`ifdef CTRL_ISSUE_SEQ_STATS_EN
   ,
   output logic [15:0] issue_cnt
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [6:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [6:0]    op_reg_q, op_reg_d;
   logic [25:0]   cw_word_q, cw_word_d;
   logic          cw_valid_q, cw_valid_d;
   logic          busy_q, busy_d;
   logic          full, empty, push, pop;

   // Full is taken from the current occupancy. A pop on the same edge does
   // not open a slot for a push.
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign push     = op_valid && !full;

   assign op_ready = !full;
   assign dec_in   = op_reg_q;
   assign cw_word  = cw_word_q;
   assign cw_valid = cw_valid_q;
   assign busy     = busy_q;

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      cw_word_d = cw_word_q;

      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            cw_word_d = dec_out;
            state_d   = HOLD;
         end
         HOLD: begin
            // Back-to-back issue: the next opcode is popped on the handshake
            // edge, so a new word appears every second cycle.
            if (cw_ready) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = DECODE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      op_reg_d = pop ? mem_q[rd_ptr_q] : op_reg_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      cw_valid_d = (state_d == HOLD);
      busy_d     = (count_d != '0) || (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         op_reg_q   <= '0;
         cw_word_q  <= '0;
         cw_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         op_reg_q   <= op_reg_d;
         cw_word_q  <= cw_word_d;
         cw_valid_q <= cw_valid_d;
         busy_q     <= busy_d;
      end
   end

   // Storage is not reset; the pointers and occupancy define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= op_code;
      end
   end

`ifdef CTRL_ISSUE_SEQ_STATS_EN
   logic [15:0] issue_cnt_q, issue_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q;
      if ((state_q == HOLD) && cw_ready && (issue_cnt_q != '1)) begin
         issue_cnt_d = issue_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign issue_cnt = issue_cnt_q;
`endif

endmodule
